// File: rtl/vecmul_pkg.sv
`default_nettype none
// ============================================================================
// Module : vecmul_pkg
// Brief  : Shared types and defaults for the vecmul datapath and its arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package vecmul_pkg;

    localparam int c_WORD_W        = 32;
    localparam int c_VSIZE_DEFAULT = 4;
    localparam int c_LAT_DEFAULT   = 4;

    typedef logic [c_WORD_W-1:0]          word_t;
    typedef word_t [c_VSIZE_DEFAULT-1:0]  vec_t;

    // Next index in a ring of n slots, wrapping to zero past the top.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vecmul_arb_if.sv
`default_nettype none
// ============================================================================
// Module : vecmul_arb_if
// Brief  : Requester, datapath and response signals of the shared vecmul
//          arbiter. slave = arbiter side, master = requesters + datapath side.
// Rev    : 1.0 - initial release
// ============================================================================
interface vecmul_arb_if
    import vecmul_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int VSIZE = c_VSIZE_DEFAULT
);
    localparam int c_ID_W = $clog2(NREQ);

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_ready;
    word_t [NREQ-1:0][VSIZE-1:0]  req_a;
    word_t [NREQ-1:0][VSIZE-1:0]  req_b;

    logic                         dp_en;
    word_t [VSIZE-1:0]            dp_in1;
    word_t [VSIZE-1:0]            dp_in2;
    word_t                        dp_result;

    logic                         rsp_valid;
    logic [c_ID_W-1:0]            rsp_id;
    word_t                        rsp_data;
    logic                         busy;

    modport slave (
        input  req_valid, req_a, req_b, dp_result,
        output req_ready, dp_en, dp_in1, dp_in2, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, dp_result,
        input  req_ready, dp_en, dp_in1, dp_in2, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/vecmul_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin grant among NREQ requesters. The search starts at the
//          pointer and wraps upward; the pointer moves past each winner.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import vecmul_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          valid,
    input  logic                     ptr_upd,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grant_id
);
    localparam int c_ID_W = $clog2(NREQ);

    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] w_cand;
    logic [c_ID_W-1:0] w_idx;
    logic              w_found;

    // First valid requester at or above the pointer, modulo NREQ; no grant in reset.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = '0;
        grant   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = c_ID_W'((32'(r_ptr) + 32'(k)) % NREQ);
            if (!w_found && valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (w_found && rst_n) begin
            grant[w_idx] = 1'b1;
        end
    end

    assign grant_id = w_idx;

    // Pointer moves one past the winner; it holds when nothing was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (ptr_upd) begin
            r_ptr <= c_ID_W'(wrap_inc(32'(w_idx), NREQ));
        end
    end

endmodule
`default_nettype wire

// File: rtl/vecmul_arb.sv
`default_nettype none
// ============================================================================
// Module : vecmul_arb
// Brief  : Shares one fixed-latency vecmul datapath between NREQ requesters.
//          Grants round-robin, registers the winner's operands onto the
//          datapath, and tracks each issue through a tag pipeline so the
//          result comes back tagged with the owning requester.
// Rev    : 1.0 - initial release
// ============================================================================
module vecmul_arb
    import vecmul_pkg::*;
#(
    parameter int VSIZE = c_VSIZE_DEFAULT,
    parameter int NREQ  = 2,
    parameter int LAT   = c_LAT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    vecmul_arb_if.slave  bus
);
    localparam int c_ID_W = $clog2(NREQ);

    logic [NREQ-1:0]           w_grant;
    logic [c_ID_W-1:0]         w_gnt_id;
    logic                      w_hs;

    logic                      r_dp_en;
    logic [c_ID_W-1:0]         r_dp_id;
    word_t [VSIZE-1:0]         r_dp_in1;
    word_t [VSIZE-1:0]         r_dp_in2;

    logic [LAT-1:0]            r_tag_vld;
    logic [LAT-1:0][c_ID_W-1:0] r_tag_id;

    logic                      r_rsp_vld;
    logic [c_ID_W-1:0]         r_rsp_id;
    word_t                     r_rsp_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (bus.req_valid),
        .ptr_upd  (w_hs),
        .grant    (w_grant),
        .grant_id (w_gnt_id)
    );

    // Grants only go to valid requesters, so any grant is a handshake.
    assign w_hs          = |w_grant;
    assign bus.req_ready = w_grant;

    // Winner's operands go to the datapath one cycle later; idle cycles drive zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_en  <= 1'b0;
            r_dp_id  <= '0;
            r_dp_in1 <= '0;
            r_dp_in2 <= '0;
        end else if (w_hs) begin
            r_dp_en  <= 1'b1;
            r_dp_id  <= w_gnt_id;
            r_dp_in1 <= bus.req_a[w_gnt_id];
            r_dp_in2 <= bus.req_b[w_gnt_id];
        end else begin
            r_dp_en  <= 1'b0;
            r_dp_in1 <= '0;
            r_dp_in2 <= '0;
        end
    end

    // Tag pipeline entered from the dp_en stage, so the last stage lines up with dp_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= r_dp_en;
            r_tag_id[0]  <= r_dp_id;
            for (int s = 1; s < LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    // Capture the datapath result against its tag; data/id hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else if (r_tag_vld[LAT-1]) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_id   <= r_tag_id[LAT-1];
            r_rsp_data <= bus.dp_result;
        end else begin
            r_rsp_vld  <= 1'b0;
        end
    end

    assign bus.dp_en     = r_dp_en;
    assign bus.dp_in1    = r_dp_in1;
    assign bus.dp_in2    = r_dp_in2;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_dp_en | (|r_tag_vld) | r_rsp_vld;

endmodule
`default_nettype wire

// File: doc/vecmul_arb.md
VECMUL_ARB -- requirements
Module: vecmul_arb

Interface
REQ-001 The block SHALL have parameter VSIZE, default 4, meaning the number of 32-bit elements per operand vector.
REQ-002 The block SHALL have parameter NREQ, default 2, range 2..8, meaning the number of requesters sharing one vecmul datapath.
REQ-003 The block SHALL have parameter LAT, default 4, range 1..16, meaning the cycles from dp_en high to the matching dp_result.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester request strobe.
REQ-007 req_ready  output  NREQ  per-requester grant, combinational.
REQ-008 req_a, req_b  input  NREQ x VSIZE x 32  per-requester operand vectors.
REQ-009 dp_en  output  1  datapath operand-valid strobe.
REQ-010 dp_in1, dp_in2  output  VSIZE x 32  datapath operand vectors.
REQ-011 dp_result  input  32  datapath dot-product result.
REQ-012 rsp_valid  output  1  result strobe, one cycle per accepted request.
REQ-013 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_data.
REQ-014 rsp_data  output  32  result word.
REQ-015 busy  output  1  high while any request is in flight.

Function
REQ-016 The arbiter SHALL assert at most one req_ready bit per cycle, and only for a requester whose req_valid is high.
REQ-017 Arbitration SHALL be round-robin: the search starts at pointer ptr and proceeds upward modulo NREQ; the first valid requester is granted.
REQ-018 After a grant to requester i, ptr SHALL become (i+1) mod NREQ; without a grant, ptr SHALL hold.
REQ-019 A handshake (req_valid and req_ready both high) in cycle t SHALL register the granted req_a/req_b onto dp_in1/dp_in2 with dp_en=1 in cycle t+1.
REQ-020 In any cycle following a cycle without a handshake, dp_en SHALL be 0 and dp_in1/dp_in2 SHALL be all zeros.
REQ-021 The block SHALL track each issue in a LAT-stage tag shift register holding {valid, id} that advances every cycle, with no stalls.
REQ-022 When the final tag stage is valid, the block SHALL register dp_result into rsp_data, the tag id into rsp_id and 1 into rsp_valid, so a handshake in cycle t yields rsp_valid in cycle t+LAT+2.
REQ-023 In cycles with no valid final tag, rsp_valid SHALL be 0 and rsp_data/rsp_id SHALL hold their previous values.
REQ-024 Back-to-back handshakes SHALL be accepted every cycle, and responses SHALL return in issue order, one per cycle, with no loss.
REQ-025 busy SHALL be high iff dp_en is high, any tag stage is valid, or rsp_valid is high.
REQ-026 A requester SHALL hold req_valid and its operands stable until granted; the block need not check this.

Reset
REQ-027 While rst_n is low, the block SHALL drive ptr=0, all tag stages invalid, dp_en=0, dp_in1/dp_in2=0, rsp_valid=0, rsp_id=0, rsp_data=0 and busy=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight tags, and no rsp_valid SHALL appear for requests issued before reset.
REQ-029 req_ready SHALL be 0 while rst_n is low.

Structure
REQ-030 Package vecmul_pkg SHALL hold typedef word_t (32-bit), typedef vec_t (VSIZE x word_t), and the default LAT constant, shared with vecmul.
REQ-031 The round-robin grant logic SHALL be a sub-module rr_arbiter, parameterised by NREQ, with ports valid, grant and ptr-update.
REQ-032 The tag pipeline and response register SHALL reside in vecmul_arb itself.

Verification
REQ-033 Single request: NREQ=2, LAT=4, req0 valid at cycle 10 with a=b={1,2,3,4} (integer model) -> dp_en at cycle 11; rsp_valid at cycle 16 with rsp_id=0 and rsp_data equal to the model value 30.
REQ-034 Contention: both requesters held valid for 4 cycles from reset -> grants in order 0,1,0,1; responses in order id 0,1,0,1 on consecutive cycles.
REQ-035 Pointer fairness: req1 granted alone, then both valid -> next grant goes to req0.
REQ-036 Streaming: req0 valid for 20 consecutive cycles -> 20 dp_en pulses back-to-back, 20 rsp_valid pulses starting LAT+2 cycles after the first handshake, busy falling one cycle after the last rsp_valid.
REQ-037 Reset mid-flight: rst_n pulled low 2 cycles after 3 handshakes -> no rsp_valid after reset release; ptr=0 and the first post-reset grant goes to req0.
REQ-038 Idle: no req_valid for 50 cycles -> dp_en=0, dp_in1/dp_in2=0, rsp_valid=0 and busy=0 throughout.
